// File: rtl/gecko_timer_controller.sv
// Gecko timer controller: a bank of down-counting timers behind a small CSR
// window, plus a one-at-a-time interrupt requester. It serves the lowest
// expired timer and captures the resume PC into that timer's return register.
module gecko_timer_controller #(
    parameter int unsigned NUM_TIMERS   = 2,
    parameter logic [31:0] VECTOR_TABLE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_write,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_hit,
    output logic        irq_valid,
    input  logic        irq_ready,
    output logic [31:0] irq_vector,
    output logic [3:0]  irq_timer,
    input  logic [31:0] resume_pc
);

    localparam logic [11:0] BASE_ADDR  = 12'hCA0;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned WIN_BYTES  = 4 * NUM_TIMERS;
    localparam int unsigned VEC_OFFSET = 16;

    typedef enum logic {
        IDLE,
        REQUEST
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        sel_q, sel_d;
    logic                    irq_valid_q, irq_valid_d;
    logic [31:0]             irq_vector_q, irq_vector_d;
    logic [IDX_W-1:0]        irq_timer_q, irq_timer_d;

    logic [NUM_TIMERS-1:0]   en_q, en_d;
    logic [NUM_TIMERS-1:0]   st_q, st_d;
    logic [31:0]             dur_q [NUM_TIMERS];
    logic [31:0]             dur_d [NUM_TIMERS];
    logic [31:0]             cnt_q [NUM_TIMERS];
    logic [31:0]             cnt_d [NUM_TIMERS];
    logic [31:0]             ret_q [NUM_TIMERS];
    logic [31:0]             ret_d [NUM_TIMERS];

    logic [NUM_TIMERS-1:0]   expired;
    logic [IDX_W-1:0]        lowest_expired;
    logic                    any_expired;
    logic                    handshake;
    logic [11:0]             offs;
    logic [IDX_W-1:0]        idx;
    logic [1:0]              off;

    assign irq_valid  = irq_valid_q;
    assign irq_vector = irq_vector_q;
    assign irq_timer  = irq_timer_q;
    assign handshake  = (state_q == REQUEST) && irq_ready;

    // Address decode: timer index and register offset inside the CSR window
    always_comb begin
        offs    = csr_addr - BASE_ADDR;
        idx     = IDX_W'(offs >> 2);
        off     = offs[1:0];
        csr_hit = (csr_addr >= BASE_ADDR) && (32'(offs) < 32'(WIN_BYTES));
    end

    // Combinational read mux; duration offset exposes the live count
    always_comb begin
        csr_rdata = '0;
        for (int i = 0; i < int'(NUM_TIMERS); i++) begin
            if (csr_hit && idx == IDX_W'(i)) begin
                case (off)
                    2'd0:    csr_rdata = {31'b0, en_q[i]};
                    2'd1:    csr_rdata = {31'b0, st_q[i]};
                    2'd2:    csr_rdata = cnt_q[i];
                    default: csr_rdata = ret_q[i];
                endcase
            end
        end
    end

    // Expiry flags and lowest-index priority pick
    always_comb begin
        expired        = '0;
        lowest_expired = '0;
        for (int i = 0; i < int'(NUM_TIMERS); i++) begin
            expired[i] = en_q[i] && (cnt_q[i] == '0);
        end
        any_expired = |expired;
        for (int i = int'(NUM_TIMERS) - 1; i >= 0; i--) begin
            if (expired[i]) begin
                lowest_expired = IDX_W'(i);
            end
        end
    end

    // Per-timer next state: count down, sticky status, CSR writes, then handshake
    always_comb begin
        en_d  = en_q;
        st_d  = st_q;
        dur_d = dur_q;
        cnt_d = cnt_q;
        ret_d = ret_q;
        for (int i = 0; i < int'(NUM_TIMERS); i++) begin
            if (en_q[i] && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 32'd1;
            end
            if (expired[i]) begin
                st_d[i] = 1'b1;
            end
            if (csr_write && csr_hit && idx == IDX_W'(i)) begin
                case (off)
                    2'd0: begin
                        if (csr_wdata[0] && !en_q[i]) begin
                            en_d[i]  = 1'b1;
                            cnt_d[i] = dur_q[i];
                            st_d[i]  = 1'b0;
                        end else if (!csr_wdata[0]) begin
                            en_d[i]  = 1'b0;
                            cnt_d[i] = cnt_q[i];
                        end
                    end
                    2'd1: begin
                        // Watchdog kick: reload wins over a same-cycle expiry
                        if (en_q[i]) begin
                            cnt_d[i] = dur_q[i];
                            st_d[i]  = 1'b0;
                        end
                    end
                    2'd2:    dur_d[i] = csr_wdata;
                    default: ;
                endcase
            end
            if (handshake && sel_q == IDX_W'(i)) begin
                en_d[i]  = 1'b0;
                ret_d[i] = resume_pc;
            end
        end
    end

    // Request FSM next state; outputs derived from the next state so they register cleanly
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        irq_valid_d  = 1'b0;
        irq_vector_d = '0;
        irq_timer_d  = '0;
        case (state_q)
            IDLE: begin
                if (any_expired) begin
                    state_d = REQUEST;
                    sel_d   = lowest_expired;
                end
            end
            REQUEST: begin
                if (irq_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == REQUEST) begin
            irq_valid_d  = 1'b1;
            irq_timer_d  = sel_d;
            irq_vector_d = VECTOR_TABLE + ((32'(sel_d) + 32'(VEC_OFFSET)) << 2);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            irq_valid_q  <= 1'b0;
            irq_vector_q <= '0;
            irq_timer_q  <= '0;
            en_q         <= '0;
            st_q         <= '0;
            for (int i = 0; i < int'(NUM_TIMERS); i++) begin
                dur_q[i] <= '0;
                cnt_q[i] <= '0;
                ret_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            irq_valid_q  <= irq_valid_d;
            irq_vector_q <= irq_vector_d;
            irq_timer_q  <= irq_timer_d;
            en_q         <= en_d;
            st_q         <= st_d;
            dur_q        <= dur_d;
            cnt_q        <= cnt_d;
            ret_q        <= ret_d;
        end
    end

endmodule

// File: tb/tb_gecko_timer_controller.sv
// Bench for gecko_timer_controller: directed scenarios plus random traffic,
// checked against a deadline-based reference model of the timer bank.
module tb_gecko_timer_controller;

    localparam int unsigned NT = 3;
    localparam logic [31:0] VT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_write;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic        irq_valid;
    logic        irq_ready;
    logic [31:0] irq_vector;
    logic [3:0]  irq_timer;
    logic [31:0] resume_pc;

    gecko_timer_controller #(.NUM_TIMERS(NT), .VECTOR_TABLE(VT)) dut (
        .clk        (clk),
        .rst        (rst),
        .csr_write  (csr_write),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .csr_hit    (csr_hit),
        .irq_valid  (irq_valid),
        .irq_ready  (irq_ready),
        .irq_vector (irq_vector),
        .irq_timer  (irq_timer),
        .resume_pc  (resume_pc)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Reference model: a running timer is a (start count, start edge) pair and
    // its count is derived from elapsed edges; a stopped timer holds a value.
    longint      ecount = 0;
    bit          m_en   [NT];
    bit          m_st   [NT];
    logic [31:0] m_dur  [NT];
    logic [31:0] m_base [NT];
    logic [31:0] m_held [NT];
    logic [31:0] m_ret  [NT];
    longint      m_t0   [NT];
    bit          m_req;
    int          m_sel;

    function automatic logic [31:0] mcnt(int i, longint at);
        longint el;
        if (!m_en[i]) return m_held[i];
        el = at - m_t0[i];
        if (longint'(m_base[i]) > el) return 32'(longint'(m_base[i]) - el);
        return 32'd0;
    endfunction

    function automatic bit in_win(logic [11:0] a);
        return (a >= 12'hCA0) && (int'(a) - int'(12'hCA0) < int'(4 * NT));
    endfunction

    function automatic logic [31:0] mread(logic [11:0] a);
        int ti, of;
        if (!in_win(a)) return 32'd0;
        ti = (int'(a) - int'(12'hCA0)) / 4;
        of = (int'(a) - int'(12'hCA0)) % 4;
        case (of)
            0:       return {31'b0, m_en[ti]};
            1:       return {31'b0, m_st[ti]};
            2:       return mcnt(ti, ecount);
            default: return m_ret[ti];
        endcase
    endfunction

    task automatic model_edge(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                              input bit rdy, input logic [31:0] pc, input bit r);
        bit ex [NT];
        bit any;
        int lo, ti, of, hs;
        if (r) begin
            for (int i = 0; i < int'(NT); i++) begin
                m_en[i] = 0; m_st[i] = 0; m_dur[i] = 0; m_base[i] = 0;
                m_held[i] = 0; m_ret[i] = 0; m_t0[i] = 0;
            end
            m_req = 0; m_sel = 0;
            ecount++;
            return;
        end
        any = 0; lo = 0;
        for (int i = int'(NT) - 1; i >= 0; i--) begin
            ex[i] = m_en[i] && (mcnt(i, ecount) == 0);
            if (ex[i]) begin any = 1; lo = i; end
            if (ex[i]) m_st[i] = 1;
        end
        hs = m_sel;
        if (wr && in_win(a)) begin
            ti = (int'(a) - int'(12'hCA0)) / 4;
            of = (int'(a) - int'(12'hCA0)) % 4;
            if (of == 0) begin
                if (wd[0] && !m_en[ti]) begin
                    m_en[ti] = 1; m_base[ti] = m_dur[ti]; m_t0[ti] = ecount + 1; m_st[ti] = 0;
                end else if (!wd[0] && m_en[ti]) begin
                    m_held[ti] = mcnt(ti, ecount); m_en[ti] = 0;
                end
            end else if (of == 1) begin
                if (m_en[ti]) begin
                    m_base[ti] = m_dur[ti]; m_t0[ti] = ecount + 1; m_st[ti] = 0;
                end
            end else if (of == 2) begin
                m_dur[ti] = wd;
            end
        end
        if (m_req && rdy) begin
            if (m_en[hs]) begin
                m_held[hs] = mcnt(hs, ecount + 1);
                m_en[hs] = 0;
            end
            m_ret[hs] = pc;
            m_req = 0;
        end else if (!m_req && any) begin
            m_req = 1;
            m_sel = lo;
        end
        ecount++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] ev;
        if (!chk_en) return;
        ev = m_req ? VT + 32'((16 + m_sel) * 4) : 32'd0;
        chk("csr_hit", 32'(csr_hit), 32'(in_win(csr_addr)));
        chk("csr_rdata", csr_rdata, mread(csr_addr));
        chk("irq_valid", 32'(irq_valid), 32'(m_req));
        chk("irq_vector", irq_vector, ev);
        chk("irq_timer", 32'(irq_timer), m_req ? 32'(m_sel) : 32'd0);
    endtask

    task automatic step(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                        input bit rdy, input logic [31:0] pc, input bit r);
        csr_write = wr; csr_addr = a; csr_wdata = wd;
        irq_ready = rdy; resume_pc = pc; rst = r;
        #1;
        check_all();
        @(posedge clk);
        model_edge(wr, a, wd, rdy, pc, r);
        #1;
    endtask

    task automatic idle();
        step(0, 12'hCA2, 32'd0, 0, 32'd0, 0);
    endtask

    task automatic peek(input string tag, input logic [11:0] a,
                        input logic [31:0] exp, input bit exp_hit);
        csr_write = 0; csr_addr = a; irq_ready = 0;
        #1;
        chk({tag, "_data"}, csr_rdata, exp);
        chk({tag, "_hit"}, 32'(csr_hit), 32'(exp_hit));
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (!irq_valid && n < 200) begin
            idle();
            n++;
        end
    endtask

    int n;
    logic [31:0] held_vec;
    logic [3:0]  held_tmr;

    initial begin
        step(0, 12'h000, 32'd0, 0, 32'd0, 1);
        chk_en = 1'b1;
        chk("reset_valid", 32'(irq_valid), 32'd0);
        chk("reset_vector", irq_vector, 32'd0);
        idle();

        // Basic latency, vector and handshake capture
        step(1, 12'hCA2, 32'd5, 0, 0, 0);
        step(1, 12'hCA0, 32'd1, 0, 0, 0);
        wait_irq(n);
        chk("lat_d5", 32'(n), 32'd6);
        chk("vec_t0", irq_vector, 32'h40);
        chk("tmr_t0", 32'(irq_timer), 32'd0);
        step(0, 12'hCA0, 32'd0, 1, 32'h100, 0);
        peek("ret_t0", 12'hCA3, 32'h100, 1);
        peek("en_t0", 12'hCA0, 32'd0, 1);
        peek("st_t0", 12'hCA1, 32'd1, 1);

        // Simultaneous expiry: lowest index first, one idle cycle between requests
        step(0, 12'hCA0, 32'd0, 0, 0, 1);
        step(1, 12'hCA6, 32'd4, 0, 0, 0);
        step(1, 12'hCA2, 32'd3, 0, 0, 0);
        step(1, 12'hCA4, 32'd1, 0, 0, 0);
        step(1, 12'hCA0, 32'd1, 0, 0, 0);
        wait_irq(n);
        chk("both_first_vec", irq_vector, 32'h40);
        peek("st_t1_in_handler", 12'hCA5, 32'd1, 1);
        step(0, 12'hCA0, 32'd0, 1, 32'h200, 0);
        chk("gap_idle", 32'(irq_valid), 32'd0);
        idle();
        chk("second_valid", 32'(irq_valid), 32'd1);
        chk("second_vec", irq_vector, 32'h44);
        chk("second_tmr", 32'(irq_timer), 32'd1);
        step(0, 12'hCA0, 32'd0, 1, 32'h300, 0);

        // Watchdog kicks keep the timer from expiring
        step(0, 12'hCA0, 32'd0, 0, 0, 1);
        step(1, 12'hCA2, 32'd10, 0, 0, 0);
        step(1, 12'hCA0, 32'd1, 0, 0, 0);
        for (int k = 0; k < 13; k++) begin
            for (int j = 0; j < 7; j++) begin
                idle();
                chk("wd_no_irq", 32'(irq_valid), 32'd0);
            end
            step(1, 12'hCA1, 32'hFFFF_FFFF, 0, 0, 0);
        end
        wait_irq(n);
        chk("wd_lat", 32'(n), 32'd11);
        step(0, 12'hCA0, 32'd0, 1, 32'h400, 0);

        // Request held stable while the core stalls, even across a disable write
        step(0, 12'hCA0, 32'd0, 0, 0, 1);
        step(1, 12'hCA2, 32'd2, 0, 0, 0);
        step(1, 12'hCA0, 32'd1, 0, 0, 0);
        wait_irq(n);
        held_vec = irq_vector;
        held_tmr = irq_timer;
        for (int k = 0; k < 20; k++) begin
            if (k == 7) step(1, 12'hCA0, 32'd0, 0, 0, 0);
            else idle();
            chk("stall_valid", 32'(irq_valid), 32'd1);
            chk("stall_vec", irq_vector, 32'h40);
            chk("stall_tmr", 32'(irq_timer), 32'(held_tmr));
        end
        chk("stall_vec_held", irq_vector, held_vec);
        step(0, 12'hCA0, 32'd0, 1, 32'h500, 0);

        // Reset during a pending request
        step(1, 12'hCA2, 32'd1, 0, 0, 0);
        step(1, 12'hCA0, 32'd1, 0, 0, 0);
        wait_irq(n);
        chk("pre_rst_valid", 32'(irq_valid), 32'd1);
        step(0, 12'hCA0, 32'd0, 1, 32'h555, 1);
        chk("rst_drop", 32'(irq_valid), 32'd0);
        peek("rst_en", 12'hCA0, 32'd0, 1);
        peek("rst_st", 12'hCA1, 32'd0, 1);
        peek("rst_ret", 12'hCA3, 32'd0, 1);
        idle();
        peek("rst_cnt", 12'hCA2, 32'd0, 1);
        peek("oob", 12'hC00, 32'd0, 0);
        step(1, 12'hCA3, 32'hDEAD_BEEF, 0, 0, 0);
        peek("ro_ret", 12'hCA3, 32'd0, 1);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic [11:0] a;
            logic [31:0] wd;
            if ($urandom_range(0, 9) == 0) a = 12'hC00;
            else a = 12'hCA0 + 12'($urandom_range(0, 4 * NT + 3));
            wd = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 12));
            step($urandom_range(0, 2) == 0, a, wd, $urandom_range(0, 2) != 0,
                 $urandom, $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
